// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and board default.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // About 1 ms of stability at a 20 MHz board clock.
    localparam int DEFAULT_STABLE_CYCLES = 20000;

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input, reset to a known level.
module sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], D};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level: synchronizer, then a counter-qualified 4-state FSM
// that commits a new level only after STABLE_CYCLES consecutive matching samples.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RAW_IN,
    output logic LEVEL,
    output logic BUSY
);

    localparam int                   CNT_WIDTH  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam state_t               IDLE_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic                 sync_out;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 level_q;
    logic                 busy_q;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (RAW_IN),
        .Q     (sync_out)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (sync_out) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    // Any low sample aborts qualification; LEVEL is untouched.
                    if (!sync_out) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync_out) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                WAIT_LO: begin
                    if (sync_out) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_STATE;
                    cnt_q   <= '0;
                    level_q <= RESET_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign LEVEL = level_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomized bench for button_debouncer, run on two instances (idle low / idle high).
module tb_button_debouncer;

    localparam int SS = 2;
    localparam int S  = 4;

    typedef struct packed {
        logic [SS-1:0] pipe;
        logic          level;
        int            run;
    } mdl_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw = 1'b0;
    logic lvl0, busy0, lvl1, busy1;

    mdl_t m0 = '0;
    mdl_t m1 = '0;
    int   rise_dut = 0, fall_dut = 0, rise_mdl = 0, fall_mdl = 0;
    logic prev_lvl0 = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(S), .RESET_LEVEL(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .RAW_IN(raw), .LEVEL(lvl0), .BUSY(busy0));

    button_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(S), .RESET_LEVEL(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .RAW_IN(raw), .LEVEL(lvl1), .BUSY(busy1));

    // Reference: LEVEL flips once S consecutive synchronized samples disagree with it;
    // the synchronized sample seen at an edge is RAW_IN as captured SS edges earlier.
    function automatic mdl_t mstep(input mdl_t m, input logic r, input logic x, input logic rl);
        mdl_t n;
        logic s;
        n = m;
        if (r) begin
            n.pipe  = {SS{rl}};
            n.level = rl;
            n.run   = 0;
        end else begin
            s      = m.pipe[SS-1];
            n.pipe = {m.pipe[SS-2:0], x};
            if (s != m.level) begin
                n.run = m.run + 1;
                if (n.run == S) begin
                    n.level = ~m.level;
                    n.run   = 0;
                end
            end else begin
                n.run = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic x);
        mdl_t nm0;
        rst = r;
        raw = x;
        @(posedge clk);
        nm0 = mstep(m0, r, x, 1'b0);
        if (!m0.level && nm0.level) rise_mdl++;
        if (m0.level && !nm0.level) fall_mdl++;
        m0 = nm0;
        m1 = mstep(m1, r, x, 1'b1);
        #1;
        if (!prev_lvl0 && lvl0 === 1'b1) rise_dut++;
        if (prev_lvl0 && lvl0 === 1'b0) fall_dut++;
        prev_lvl0 = lvl0;
        chk("level0", lvl0, m0.level);
        chk("busy0", busy0, m0.run != 0);
        chk("level1", lvl1, m1.level);
        chk("busy1", busy1, m1.run != 0);
    endtask

    task automatic settle(input logic x);
        for (int i = 0; i < 10; i++) step(1'b0, x);
    endtask

    initial begin
        logic [8:0] bounce;
        bounce = 9'b1_1110_1101;

        // Reset held three cycles with RAW_IN high
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            chk("rst_level0", lvl0, 1'b0);
            chk("rst_busy0", busy0, 1'b0);
            chk("rst_level1", lvl1, 1'b1);
        end
        prev_lvl0 = lvl0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b1);
            if (e == 5) chk("post_rst_e5", lvl0, 1'b0);
            if (e == 6) chk("post_rst_e6", lvl0, 1'b1);
        end

        // Clean press: capture edge is j=0
        settle(1'b0);
        chk("settled_low", lvl0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b1);
            if (j == 1) chk("press_busy_k1", busy0, 1'b0);
            if (j == 2) chk("press_busy_k2", busy0, 1'b1);
            if (j == 4) chk("press_lvl_k4", lvl0, 1'b0);
            if (j == 5) chk("press_lvl_k5", lvl0, 1'b1);
            if (j == 5) chk("press_busy_k5", busy0, 1'b0);
        end

        // Release: falls five edges after capture
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b0);
            if (j == 4) chk("rel_lvl_k4", lvl0, 1'b1);
            if (j == 5) chk("rel_lvl_k5", lvl0, 1'b0);
        end

        // Bounce 1,0,1,1,0,1,1,1,1: last zero captured at j=4, first of four ones at j=5
        for (int j = 0; j < 14; j++) begin
            step(1'b0, (j < 9) ? bounce[j] : 1'b1);
            if (j == 9) chk("bounce_lvl_j9", lvl0, 1'b0);
            if (j == 10) chk("bounce_lvl_j10", lvl0, 1'b1);
        end

        // Short glitch from low: three high cycles must never commit
        settle(1'b0);
        for (int j = 0; j < 12; j++) begin
            step(1'b0, (j < 3) ? 1'b1 : 1'b0);
            chk("glitch_lvl", lvl0, 1'b0);
            if (j == 3) chk("glitch_busy", busy0, 1'b1);
        end
        chk("glitch_idle", busy0, 1'b0);

        // Reset while qualifying a rise, after the counter has reached two
        settle(1'b0);
        for (int j = 0; j < 10 && m0.run != 2; j++) step(1'b0, 1'b1);
        chk_int("midwait_run", m0.run, 2);
        step(1'b1, 1'b1);
        chk("midwait_lvl0", lvl0, 1'b0);
        chk("midwait_busy0", busy0, 1'b0);
        chk("midwait_lvl1", lvl1, 1'b1);
        chk("midwait_busy1", busy1, 1'b0);
        settle(1'b0);

        // Randomized bouncy input with occasional resets
        for (int n = 0; n < 120; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) step(($urandom_range(0, 79) == 0), v);
        end
        settle(1'b0);

        chk_int("edge_rises", rise_dut, rise_mdl);
        chk_int("edge_falls", fall_dut, fall_mdl);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Cleans a raw asynchronous push-button or switch input into a glitch-free, clock-synchronous level.
- Sits directly upstream of the posedge/negedge edge-detect stage. Its LEVEL output drives that stage's SIGNAL input, so each physical press yields exactly one edge pulse.
- Internals: a synchronizer chain followed by a counter-qualified 4-state FSM. A new level is committed only after it has held for STABLE_CYCLES consecutive samples.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops; legal values are 2 or more.
- STABLE_CYCLES, 20000: consecutive matching samples required before LEVEL changes; legal values are 2 or more.
- RESET_LEVEL, 0: value of LEVEL and of all synchronizer flops after reset. It matches the downstream detector's idle level (0 for posedge use, 1 for negedge use).
- CNT_WIDTH, $clog2(STABLE_CYCLES+1): derived localparam, not overridable.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK
- RAW_IN  input  1  asynchronous raw button/switch level
- LEVEL  output  1  debounced, registered level
- BUSY  output  1  1 while a candidate level change is being qualified

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. All state updates occur on posedge CLK only.
- Reset values: sync flops = RESET_LEVEL; state = STABLE_LO if RESET_LEVEL is 0, else STABLE_HI; cnt = 0; LEVEL = RESET_LEVEL; BUSY = 0.
- Synchronizer: RAW_IN is captured into sync[0] at edge k. It appears on sync_out (sync[SYNC_STAGES-1]) after edge k+SYNC_STAGES-1.
- States: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO:
  - sync_out=1: go to WAIT_HI, cnt <= 1.
  - Otherwise: hold, cnt <= 0.
- WAIT_HI:
  - sync_out=0: go to STABLE_LO, cnt <= 0. The glitch is rejected and LEVEL is unchanged.
  - sync_out=1 and cnt == STABLE_CYCLES-1: go to STABLE_HI, LEVEL <= 1, cnt <= 0.
  - sync_out=1 otherwise: cnt <= cnt+1.
- STABLE_HI and WAIT_LO: mirror of the above with the polarity inverted.
- LEVEL is registered and changes only on the commit edge. It never toggles twice within STABLE_CYCLES+1 cycles.
- BUSY: registered, = 1 exactly while state is WAIT_HI or WAIT_LO.
- Latency: a clean step captured at edge k commits LEVEL at edge k+SYNC_STAGES+STABLE_CYCLES-1. Example: with SYNC_STAGES=2 and STABLE_CYCLES=4, LEVEL changes at edge k+5.
- Any mismatching sample during a WAIT state restarts qualification from zero. A bounce inside the window therefore extends latency.
- Counter: cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around. Counter width is CNT_WIDTH.
- Reset mid-qualification: on the next edge, state, cnt, LEVEL and sync return to their reset values. No partial commit occurs.
- RAW_IN already at ~RESET_LEVEL when reset releases: this is debounced as a normal change and LEVEL flips after the full latency.
- RESET and a commit condition on the same edge: RESET wins.
- Unreachable state encodings: recover to the RESET_LEVEL stable state on the next edge.

Decomposition:
- Shared package: state encoding localparams STABLE_LO=2'd0, WAIT_HI=2'd1, STABLE_HI=2'd2, WAIT_LO=2'd3, plus the default STABLE_CYCLES constant used for board builds.
- One sub-module, sync_chain:
  - Parameters: SYNC_STAGES, RESET_LEVEL.
  - Ports: CLK, RESET, D, Q.
  - Reusable for other asynchronous board inputs.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0 unless stated):
- Reset: hold RESET 3 cycles with RAW_IN=1 -> LEVEL=0 and BUSY=0 throughout; after release, LEVEL=1 at the 6th edge counted from the first sampling edge.
- Clean press: RAW_IN steps 0->1 captured at edge 10 -> BUSY=1 after edge 12, LEVEL=1 after edge 15, BUSY=0 after edge 15.
- Bounce: RAW_IN pattern 1,0,1,1,0,1,1,1,1 on successive edges from edge 20 -> LEVEL stays 0 until 4 consecutive 1s reach sync_out, then rises exactly once.
- Short glitch: RAW_IN=1 for 3 cycles, then 0 -> LEVEL never changes; BUSY pulses high and returns to 0.
- Release: from LEVEL=1, RAW_IN steps 1->0 -> LEVEL=0 five edges after capture; feeding LEVEL into the posedge/negedge detector yields exactly one EDGE pulse per press/release.
- Reset mid-wait: assert RESET while in WAIT_HI with cnt=2 -> next edge gives LEVEL=0, BUSY=0, cnt=0; rerun with RESET_LEVEL=1 -> LEVEL=1 after reset.
